assoc_cache: RTL

Parametrised N-way set-associative, blocking cache with a built-in miss-handling FSM. It replaces the fixed 2-way lookup-only array in both the I-side (WRITE_BACK=0) and D-side (WRITE_BACK=1) memory paths. Features:
- True round-robin/invalid-first replacement.
- Byte-masked stores.
- Write-allocate with dirty-victim write-back.
- A valid/ready memory port toward the DRAM model.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_victim_sel.sv | 20 ++
 rtl/assoc_cache.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, address-field width helpers and byte-merge for assoc_cache.
// Contents:
//   state_e                    miss-handling FSM states
//   offset_w/set_w/tag_w/way_w address field and way-index widths
//   byte_merge                 overlay strobed bytes of wdata onto a line (lines up to MAX_BYTES bytes)
package cache_pkg;
    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL_REQ, FILL_WAIT, RESP} state_e;
    localparam int MAX_BYTES = 128;
    localparam int MAX_LINE = 8 * MAX_BYTES;
    function automatic int offset_w(input int block_bytes);
        return $clog2(block_bytes);
    endfunction
    function automatic int set_w(input int num_sets);
        return $clog2(num_sets);
    endfunction
    function automatic int tag_w(input int addr_width, input int num_sets, input int block_bytes);
        return addr_width - $clog2(num_sets) - $clog2(block_bytes);
    endfunction
    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction
    // Callers zero-extend into the maximum width and truncate the result back.
    function automatic logic [MAX_LINE-1:0] byte_merge(input logic [MAX_LINE-1:0] line,
                                                       input logic [MAX_LINE-1:0] wdata,
                                                       input logic [MAX_BYTES-1:0] wstrb);
        logic [MAX_LINE-1:0] r;
        r = line;
        for (int b = 0; b < MAX_BYTES; b++)
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the replacement way of a set - lowest invalid way, else the round-robin pointer.
// Ports:
//   valid_i   per-way valid bits of the set
//   rr_i      round-robin pointer of the set
//   victim_o  selected way index
module cache_victim_sel import cache_pkg::*; #(
    parameter int NUM_WAYS = 2,
    parameter int WB = way_w(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic [WB-1:0]       rr_i,
    output logic [WB-1:0]       victim_o
);
    // Scanning downward leaves the lowest invalid way as the final pick.
    always_comb begin
        victim_o = rr_i;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid_i[i]) victim_o = WB'(i);
    end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative blocking cache with miss FSM, byte-masked stores and dirty write-back.
// Ports:
//   clk, rst_aL                      clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_addr/req_we/req_wstrb/req_wdata  request address, store flag, byte enables, store data
//   resp_valid/resp_hit/resp_data    one-cycle response, first-lookup hit flag, merged line
//   mem_req_valid/mem_req_ready      memory request handshake
//   mem_req_we/mem_req_addr/mem_req_wdata  write-back (1) or fill (0), line address, victim line
//   mem_resp_valid/mem_resp_data     fill return, accepted only in FILL_WAIT
module assoc_cache import cache_pkg::*; #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SETS    = 64,
    parameter int NUM_WAYS    = 2,
    parameter int BLOCK_BYTES = 8,
    parameter int WRITE_BACK  = 0
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic                     req_we,
    input  logic [BLOCK_BYTES-1:0]   req_wstrb,
    input  logic [8*BLOCK_BYTES-1:0] req_wdata,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [8*BLOCK_BYTES-1:0] resp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [8*BLOCK_BYTES-1:0] mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [8*BLOCK_BYTES-1:0] mem_resp_data
);
    localparam int OB = offset_w(BLOCK_BYTES);
    localparam int SB = set_w(NUM_SETS);
    localparam int TB = tag_w(ADDR_WIDTH, NUM_SETS, BLOCK_BYTES);
    localparam int WB = way_w(NUM_WAYS);
    localparam int LW = 8 * BLOCK_BYTES;
    localparam int LA = ADDR_WIDTH - OB;
    state_e state_q, state_d;
    logic [LA-1:0] line_q, line_d;
    logic we_q, we_d;
    logic [BLOCK_BYTES-1:0] wstrb_q, wstrb_d;
    logic [LW-1:0] wdata_q, wdata_d;
    logic [WB-1:0] victim_q, victim_d;
    logic [LW-1:0] resp_line_q, resp_line_d;
    logic resp_hit_q, resp_hit_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LW-1:0] mem_wdata_q, mem_wdata_d;
    logic [TB-1:0] tag_q [NUM_SETS][NUM_WAYS];
    logic [LW-1:0] data_q [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [WB-1:0] rr_q [NUM_SETS];
    logic [SB-1:0] set;
    logic [TB-1:0] tag;
    logic [NUM_WAYS-1:0] hit_vec;
    logic [WB-1:0] hit_way, victim, rr_next;
    logic hit, wr;
    logic [LW-1:0] hit_line, store_line, fill_line;
    logic unused_offset;
    assign unused_offset = ^req_addr[OB-1:0];
    assign set = line_q[SB-1:0];
    assign tag = line_q[LA-1:SB];
    // Stores are only honoured in the write-back configuration.
    assign wr = we_q && (WRITE_BACK != 0);
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[set][w] && (tag_q[set][w] == tag);
            if (hit_vec[w]) hit_way = WB'(w);
        end
    end
    assign hit = |hit_vec;
    assign hit_line = data_q[set][hit_way];
    assign store_line = wr ? LW'(byte_merge(MAX_LINE'(hit_line), MAX_LINE'(wdata_q), MAX_BYTES'(wstrb_q))) : hit_line;
    assign fill_line = wr ? LW'(byte_merge(MAX_LINE'(mem_resp_data), MAX_LINE'(wdata_q), MAX_BYTES'(wstrb_q))) : mem_resp_data;
    assign rr_next = (victim_q == WB'(NUM_WAYS - 1)) ? '0 : victim_q + 1'b1;
    cache_victim_sel #(.NUM_WAYS(NUM_WAYS), .WB(WB)) u_victim (
        .valid_i (valid_q[set]),
        .rr_i    (rr_q[set]),
        .victim_o(victim)
    );
    always_comb begin
        state_d = state_q;
        line_d = line_q;
        we_d = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        victim_d = victim_q;
        resp_line_d = resp_line_q;
        resp_hit_d = resp_hit_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                line_d = req_addr[ADDR_WIDTH-1:OB];
                we_d = req_we;
                wstrb_d = req_wstrb;
                wdata_d = req_wdata;
                state_d = LOOKUP;
            end
            LOOKUP: if (hit) begin
                resp_line_d = store_line;
                resp_hit_d = 1'b1;
                state_d = RESP;
            end else begin
                victim_d = victim;
                if (WRITE_BACK != 0 && valid_q[set][victim] && dirty_q[set][victim]) begin
                    mem_addr_d = {tag_q[set][victim], set, {OB{1'b0}}};
                    mem_wdata_d = data_q[set][victim];
                    state_d = EVICT;
                end else begin
                    mem_addr_d = {line_q, {OB{1'b0}}};
                    state_d = FILL_REQ;
                end
            end
            EVICT: if (mem_req_ready) begin
                mem_addr_d = {line_q, {OB{1'b0}}};
                state_d = FILL_REQ;
            end
            FILL_REQ: if (mem_req_ready) state_d = FILL_WAIT;
            FILL_WAIT: if (mem_resp_valid) begin
                resp_line_d = fill_line;
                resp_hit_d = 1'b0;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q <= IDLE;
            line_q <= '0;
            we_q <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            victim_q <= '0;
            resp_line_q <= '0;
            resp_hit_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            line_q <= line_d;
            we_q <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            victim_q <= victim_d;
            resp_line_q <= resp_line_d;
            resp_hit_q <= resp_hit_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit && wr) data_q[set][hit_way] <= store_line;
        if (state_q == FILL_WAIT && mem_resp_valid) begin
            data_q[set][victim_q] <= fill_line;
            tag_q[set][victim_q] <= tag;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s] <= '0;
            end
        end else begin
            if (state_q == LOOKUP && hit && wr) dirty_q[set][hit_way] <= 1'b1;
            if (state_q == FILL_WAIT && mem_resp_valid) begin
                valid_q[set][victim_q] <= 1'b1;
                dirty_q[set][victim_q] <= wr;
                rr_q[set] <= rr_next;
            end
        end
    end
    always_ff @(posedge clk)
        if (rst_aL && state_q == LOOKUP) assert ($onehot0(hit_vec));
    assign req_ready = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_hit = (state_q == RESP) && resp_hit_q;
    assign resp_data = resp_line_q;
    assign mem_req_valid = (state_q == EVICT) || (state_q == FILL_REQ);
    assign mem_req_we = (state_q == EVICT);
    assign mem_req_addr = mem_addr_q;
    assign mem_req_wdata = mem_wdata_q;
endmodule
